// File: rtl/enc_history_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enc_history_display_pkg
// Brief    : Shared types, segment constants and glyph table for the
//            encoder history seven-segment display.
// Revision : 1.0 - initial release
// ============================================================================
package enc_history_display_pkg;

  // Number of multiplexed digits on the board display
  localparam int DIGITS = 4;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Encoder index type (0-7)
  typedef logic [2:0] idx_t;

  // Glyph table for the digits 0-7, active-low
  function automatic logic [6:0] glyph(input idx_t i);
    logic [6:0] g;
    case (i)
      3'd0:    g = 7'b1000000;
      3'd1:    g = 7'b1111001;
      3'd2:    g = 7'b0100100;
      3'd3:    g = 7'b0110000;
      3'd4:    g = 7'b0011001;
      3'd5:    g = 7'b0010010;
      3'd6:    g = 7'b0000010;
      default: g = 7'b1111000;
    endcase
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_history_display_seg7_glyph.sv
`default_nettype none
// ============================================================================
// Module   : seg7_glyph
// Brief    : Combinational seven-segment decoder. Shows the glyph of idx when
//            show is set, a dash when only dash is set, otherwise blank.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_glyph
  import enc_history_display_pkg::*;
(
  input  logic [2:0] idx,
  input  logic       show,
  input  logic       dash,
  output logic [6:0] seg
);

  // show has priority over dash; neither means the digit is dark
  always_comb begin
    seg = SEG_BLANK;
    if (show) begin
      seg = glyph(idx);
    end else if (dash) begin
      seg = SEG_DASH;
    end
  end

endmodule
`default_nettype wire

// File: rtl/enc_history_display.sv
`default_nettype none
// ============================================================================
// Module   : enc_history_display
// Brief    : Drives a 4-digit multiplexed seven-segment display from the
//            priority encoder: digit 0 shows the live index (dash when
//            invalid), digits 1-3 show the last three distinct accepted
//            indices.
// Revision : 1.0 - initial release
// ============================================================================
module enc_history_display
  import enc_history_display_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code,
  input  logic       valid,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  // Synchroniser chains; the last stage is the clean view of the inputs
  logic [SYNC_STAGES-1:0][2:0] code_sync_q, code_sync_d;
  logic [SYNC_STAGES-1:0]      valid_sync_q, valid_sync_d;
  idx_t                        cs;
  logic                        vs;

  // Last accepted index and the three-deep history behind it
  idx_t                        last_q, last_d;
  logic                        last_vld_q, last_vld_d;
  logic [3:1][2:0]             hist_q, hist_d;
  logic [3:1]                  hist_vld_q, hist_vld_d;
  logic                        accept;

  // Scan timing
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [1:0]                  digit_q, digit_d;

  // Display output registers and the glyph decoder select
  logic [6:0]                  seg_q, seg_d;
  logic [DIGITS-1:0]           an_q, an_d;
  logic                        dp_q, dp_d;
  idx_t                        sel_idx;
  logic                        sel_show;
  logic                        sel_dash;

  assign cs = code_sync_q[SYNC_STAGES-1];
  assign vs = valid_sync_q[SYNC_STAGES-1];

  // Shift the asynchronous inputs one stage further down each chain
  always_comb begin
    code_sync_d     = '0;
    valid_sync_d    = '0;
    code_sync_d[0]  = code;
    valid_sync_d[0] = valid;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      code_sync_d[i]  = code_sync_q[i-1];
      valid_sync_d[i] = valid_sync_q[i-1];
    end
  end

  // Accept a valid index only when it differs from the last one accepted,
  // so a steady code or one returning after an invalid gap is taken once
  always_comb begin
    accept     = vs & (~last_vld_q | (cs != last_q));
    last_d     = last_q;
    last_vld_d = last_vld_q;
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    if (accept) begin
      hist_d[3]     = hist_q[2];
      hist_vld_d[3] = hist_vld_q[2];
      hist_d[2]     = hist_q[1];
      hist_vld_d[2] = hist_vld_q[1];
      hist_d[1]     = last_q;
      hist_vld_d[1] = last_vld_q;
      last_d        = cs;
      last_vld_d    = 1'b1;
    end
  end

  // Each digit stays lit for SCAN_DIV cycles, then the next one is selected
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
    end
  end

  // Choose what the current digit shows; values are pre-accept this cycle
  always_comb begin
    an_d     = ~(DIGITS'(1) << digit_q);
    sel_idx  = cs;
    sel_show = vs;
    sel_dash = ~vs;
    dp_d     = 1'b1;
    case (digit_q)
      2'd0: begin
        dp_d = vs;
      end
      2'd1: begin
        sel_idx  = hist_q[1];
        sel_show = hist_vld_q[1];
        sel_dash = 1'b0;
      end
      2'd2: begin
        sel_idx  = hist_q[2];
        sel_show = hist_vld_q[2];
        sel_dash = 1'b0;
      end
      default: begin
        sel_idx  = hist_q[3];
        sel_show = hist_vld_q[3];
        sel_dash = 1'b0;
      end
    endcase
  end

  seg7_glyph u_glyph (
    .idx  (sel_idx),
    .show (sel_show),
    .dash (sel_dash),
    .seg  (seg_d)
  );

  // State and output registers; reset blanks the display and drops history
  always_ff @(posedge clk) begin
    if (rst) begin
      code_sync_q  <= '0;
      valid_sync_q <= '0;
      last_q       <= '0;
      last_vld_q   <= 1'b0;
      hist_q       <= '0;
      hist_vld_q   <= '0;
      cnt_q        <= '0;
      digit_q      <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      dp_q         <= 1'b1;
    end else begin
      code_sync_q  <= code_sync_d;
      valid_sync_q <= valid_sync_d;
      last_q       <= last_d;
      last_vld_q   <= last_vld_d;
      hist_q       <= hist_d;
      hist_vld_q   <= hist_vld_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_enc_history_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc_history_display
// Brief    : Directed self-checking bench for enc_history_display with
//            SCAN_DIV=4, SYNC_STAGES=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enc_history_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] code;
  logic       valid;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] G2    = 7'b0100100;
  localparam logic [6:0] G3    = 7'b0110000;
  localparam logic [6:0] G5    = 7'b0010010;
  localparam logic [6:0] G6    = 7'b0000010;
  localparam logic [6:0] G7    = 7'b1111000;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  enc_history_display #(
    .SCAN_DIV    (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .code  (code),
    .valid (valid),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [2:0] c, input int n);
    code  = c;
    valid = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance to the first cycle of the slot where digit k becomes lit
  task automatic wait_digit(input int k);
    logic [3:0] tgt;
    int n;
    tgt = 4'b0001 << k;
    tgt = ~tgt;
    n   = 0;
    while (an === tgt && n < 40) begin tick(); n++; end
    while (an !== tgt && n < 40) begin tick(); n++; end
    checks++;
    if (an !== tgt) begin
      errors++;
      $display("FAIL wait_digit%0d: an=%b required %b (timeout)", k, an, tgt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; code = 3'd0;
    tick(); tick();
    checks++;
    if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: an=%b seg=%b dp=%b required 1111 1111111 1", an, seg, dp);
    end
    checks++;
    if (dut.last_vld_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_lvld: got %b required 0", dut.last_vld_q);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({an, seg, dp} !== {4'b1110, DASH, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: an=%b seg=%b dp=%b required 1110 0111111 0", an, seg, dp);
    end
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         d;
    for (int e = 2; e <= 16; e++) begin
      tick();
      d       = (e - 1) / 4;
      exp_an  = 4'b0001 << d;
      exp_an  = ~exp_an;
      exp_seg = (d == 0) ? DASH : BLANK;
      exp_dp  = (d == 0) ? 1'b0 : 1'b1;
      checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL idle_scan edge%0d: an=%b seg=%b dp=%b required %b %b %b",
                 e, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_first_accept();
    code = 3'd5; valid = 1'b1;
    tick(); tick();
    checks++;
    if (dut.last_vld_q !== 1'b0) begin
      errors++;
      $display("FAIL accept_early: L_vld=%b required 0 two cycles after edge", dut.last_vld_q);
    end
    tick();
    checks++;
    if ({dut.last_vld_q, dut.last_q} !== {1'b1, 3'd5}) begin
      errors++;
      $display("FAIL accept_latency: L_vld=%b L=%0d required 1 5", dut.last_vld_q, dut.last_q);
    end
    wait_digit(0);
    checks++;
    if ({seg, dp} !== {G5, 1'b1}) begin
      errors++;
      $display("FAIL first_digit0: seg=%b dp=%b required %b 1", seg, dp, G5);
    end
    for (int k = 1; k <= 3; k++) begin
      wait_digit(k);
      checks++;
      if ({seg, dp} !== {BLANK, 1'b1}) begin
        errors++;
        $display("FAIL first_hist%0d: seg=%b dp=%b required 1111111 1", k, seg, dp);
      end
    end
  endtask

  task automatic test_sequence();
    logic [6:0] exp [4];
    hold(3'd2, 20); hold(3'd7, 20); hold(3'd3, 20);
    exp[0] = G3; exp[1] = G7; exp[2] = G2; exp[3] = G5;
    for (int k = 0; k < 4; k++) begin
      wait_digit(k);
      checks++;
      if ({seg, dp} !== {exp[k], 1'b1}) begin
        errors++;
        $display("FAIL seq_a digit%0d: seg=%b dp=%b required %b 1", k, seg, dp, exp[k]);
      end
    end
    hold(3'd6, 20);
    exp[0] = G6; exp[1] = G3; exp[2] = G7; exp[3] = G2;
    for (int k = 0; k < 4; k++) begin
      wait_digit(k);
      checks++;
      if ({seg, dp} !== {exp[k], 1'b1}) begin
        errors++;
        $display("FAIL seq_b digit%0d: seg=%b dp=%b required %b 1", k, seg, dp, exp[k]);
      end
    end
  endtask

  task automatic test_gap_same_code();
    logic [6:0] exp [4];
    hold(3'd2, 20);
    wait_digit(0);
    valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({an, seg, dp} !== {4'b1110, DASH, 1'b0}) begin
      errors++;
      $display("FAIL gap_dash: an=%b seg=%b dp=%b required 1110 0111111 0", an, seg, dp);
    end
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if ({dut.last_vld_q, dut.last_q} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL gap_hold_L: L_vld=%b L=%0d required 1 2", dut.last_vld_q, dut.last_q);
    end
    hold(3'd2, 20);
    exp[0] = G2; exp[1] = G6; exp[2] = G3; exp[3] = G7;
    for (int k = 0; k < 4; k++) begin
      wait_digit(k);
      checks++;
      if ({seg, dp} !== {exp[k], 1'b1}) begin
        errors++;
        $display("FAIL gap_reaccept digit%0d: seg=%b dp=%b required %b 1", k, seg, dp, exp[k]);
      end
    end
  endtask

  task automatic test_glitch();
    logic [6:0] exp [4];
    code = 3'd4; valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if ({dut.last_vld_q, dut.last_q} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL glitch_L: L_vld=%b L=%0d required 1 4", dut.last_vld_q, dut.last_q);
    end
    exp[0] = DASH; exp[1] = G2; exp[2] = G6; exp[3] = G3;
    for (int k = 0; k < 4; k++) begin
      wait_digit(k);
      checks++;
      if ({seg, dp} !== {exp[k], (k == 0) ? 1'b0 : 1'b1}) begin
        errors++;
        $display("FAIL glitch digit%0d: seg=%b dp=%b required %b", k, seg, dp, exp[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_digit(2);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL midreset_outputs: an=%b seg=%b dp=%b required 1111 1111111 1", an, seg, dp);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({an, seg, dp} !== {4'b1110, DASH, 1'b0}) begin
      errors++;
      $display("FAIL midreset_release: an=%b seg=%b dp=%b required 1110 0111111 0", an, seg, dp);
    end
    checks++;
    if (dut.last_vld_q !== 1'b0) begin
      errors++;
      $display("FAIL midreset_lvld: got %b required 0", dut.last_vld_q);
    end
    for (int k = 1; k <= 3; k++) begin
      wait_digit(k);
      checks++;
      if ({seg, dp} !== {BLANK, 1'b1}) begin
        errors++;
        $display("FAIL midreset_hist%0d: seg=%b dp=%b required 1111111 1", k, seg, dp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; code = 3'd0; valid = 1'b0;
    test_reset();
    test_idle_scan();
    test_first_accept();
    test_sequence();
    test_gap_same_code();
    test_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
